// File: rtl/rp_spi_pkg.sv
// ---------------------------------------------------------------------------
// rp_spi_pkg
// Shared definitions for the SPI trigger receiver slice:
//   spi_rx_state_t : receiver FSM states
//   DEF_OPW        : default opcode field width
//   DEF_TRIG_OP    : default opcode value that fires a trigger
//   TRIG_CNT_W     : width of the wrapping trigger counter
// ---------------------------------------------------------------------------
package rp_spi_pkg;

   typedef enum logic [1:0] {
      WAIT_IDLE = 2'd0,  // after reset: wait for cs high so a partial frame is skipped
      IDLE      = 2'd1,  // cs high, waiting for a frame to start
      SHIFT     = 2'd2   // cs low, shifting bits in and out
   } spi_rx_state_t;

   localparam int         DEF_OPW     = 4;
   localparam logic [3:0] DEF_TRIG_OP = 4'hA;
   localparam int         TRIG_CNT_W  = 16;

endpackage

// File: rtl/rp_spi_sync.sv
// ---------------------------------------------------------------------------
// rp_spi_sync
// Two-flop synchronizer for one asynchronous input, followed by a register
// stage that produces the synchronized level together with registered
// rise/fall strobes. Level and strobes change on the same clk edge, so a
// consumer sees a strobe and the matching level in the same cycle.
//   clk  : system clock
//   rst  : synchronous active-high reset (all stages to 0)
//   d    : asynchronous input
//   q    : synchronized level
//   rise : one-cycle strobe on a 0->1 transition of q
//   fall : one-cycle strobe on a 1->0 transition of q
// ---------------------------------------------------------------------------
module rp_spi_sync (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [1:0] meta;

   // NOTE: sequential state is always assigned with <= so every flop samples
   // the pre-edge value of its neighbour; with = the chain would collapse.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= '0;
         q    <= 1'b0;
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         meta <= {meta[0], d};
         q    <= meta[1];
         rise <= meta[1] & ~q;
         fall <= ~meta[1] & q;
      end
   end

endmodule

// File: rtl/rp_spi_trig_rx.sv
// ---------------------------------------------------------------------------
// rp_spi_trig_rx
// SPI mode-0 slave receiver, oversampled in the clk domain. Each frame of
// exactly DW bits is presented on rx_data with a one-cycle rx_valid; frames
// whose top OPW bits equal TRIG_OP also pulse trig and bump trig_cnt.
// Frames of any other length pulse err_len and leave rx_data untouched.
//   clk      : system clock
//   rst      : synchronous active-high reset
//   cs       : chip select, active low (asynchronous)
//   sclk     : SPI clock, CPOL=0 CPHA=0 (asynchronous)
//   mosi     : serial data in, MSB first
//   miso     : serial data out, MSB first; 0 outside a frame
//   tx_data  : word to transmit, sampled at the start of each frame
//   rx_data  : last correctly sized received word
//   rx_valid : one-cycle pulse when rx_data updates
//   trig     : one-cycle pulse with rx_valid when the opcode matches
//   trig_cnt : number of triggers fired, wrapping
//   err_len  : one-cycle pulse when a frame ends with the wrong bit count
// ---------------------------------------------------------------------------
module rp_spi_trig_rx
   import rp_spi_pkg::*;
#(
   parameter int             DW      = 16,
   parameter int             OPW     = DEF_OPW,
   parameter logic [OPW-1:0] TRIG_OP = DEF_TRIG_OP
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cs,
   input  logic                  sclk,
   input  logic                  mosi,
   output logic                  miso,
   input  logic [DW-1:0]         tx_data,
   output logic [DW-1:0]         rx_data,
   output logic                  rx_valid,
   output logic                  trig,
   output logic [TRIG_CNT_W-1:0] trig_cnt,
   output logic                  err_len
);

   // Bit counter must reach DW+1 so an over-long frame stays distinguishable
   // from a correct one no matter how many extra clocks arrive.
   localparam int            CW       = $clog2(DW + 2);
   localparam logic [CW-1:0] CNT_FULL = CW'(DW);
   localparam logic [CW-1:0] CNT_SAT  = CW'(DW + 1);

   // ------------------------------------------------------------------
   // Input synchronization
   // ------------------------------------------------------------------
   logic cs_s, cs_rise, cs_fall;
   logic sclk_s_unused, sclk_rise, sclk_fall;
   logic mosi_s, mosi_rise_unused, mosi_fall_unused;

   rp_spi_sync u_sync_cs (
      .clk  (clk),
      .rst  (rst),
      .d    (cs),
      .q    (cs_s),
      .rise (cs_rise),
      .fall (cs_fall)
   );

   rp_spi_sync u_sync_sclk (
      .clk  (clk),
      .rst  (rst),
      .d    (sclk),
      .q    (sclk_s_unused),
      .rise (sclk_rise),
      .fall (sclk_fall)
   );

   rp_spi_sync u_sync_mosi (
      .clk  (clk),
      .rst  (rst),
      .d    (mosi),
      .q    (mosi_s),
      .rise (mosi_rise_unused),
      .fall (mosi_fall_unused)
   );

   // ------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------
   spi_rx_state_t         state, state_nxt;
   // The MSB of tx_data goes straight to miso at frame start, so the
   // shifter only holds the remaining DW-1 bits.
   logic [DW-2:0]         tx_sh, tx_sh_nxt;
   logic [DW-1:0]         rx_sh, rx_sh_nxt;
   logic [CW-1:0]         bit_cnt, bit_cnt_nxt;
   logic                  miso_nxt;
   logic [DW-1:0]         rx_data_nxt;
   logic                  rx_valid_nxt, trig_nxt, err_len_nxt;
   logic [TRIG_CNT_W-1:0] trig_cnt_nxt;
   logic [OPW-1:0]        opcode;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= WAIT_IDLE;
         tx_sh    <= '0;
         rx_sh    <= '0;
         bit_cnt  <= '0;
         miso     <= 1'b0;
         rx_data  <= '0;
         rx_valid <= 1'b0;
         trig     <= 1'b0;
         err_len  <= 1'b0;
         trig_cnt <= '0;
      end else begin
         state    <= state_nxt;
         tx_sh    <= tx_sh_nxt;
         rx_sh    <= rx_sh_nxt;
         bit_cnt  <= bit_cnt_nxt;
         miso     <= miso_nxt;
         rx_data  <= rx_data_nxt;
         rx_valid <= rx_valid_nxt;
         trig     <= trig_nxt;
         err_len  <= err_len_nxt;
         trig_cnt <= trig_cnt_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Next-state / datapath logic
   // ------------------------------------------------------------------
   // NOTE: every signal written here gets a default on the first lines so no
   // path through the case leaves one unassigned and infers a latch.
   always_comb begin
      state_nxt    = state;
      tx_sh_nxt    = tx_sh;
      rx_sh_nxt    = rx_sh;
      bit_cnt_nxt  = bit_cnt;
      miso_nxt     = 1'b0;
      rx_data_nxt  = rx_data;
      rx_valid_nxt = 1'b0;
      trig_nxt     = 1'b0;
      err_len_nxt  = 1'b0;
      trig_cnt_nxt = trig_cnt;
      opcode       = rx_sh[DW-1 -: OPW];

      case (state)
         WAIT_IDLE: begin
            if (cs_s) begin
               state_nxt = IDLE;
            end
         end

         IDLE: begin
            if (cs_fall) begin
               state_nxt   = SHIFT;
               tx_sh_nxt   = tx_data[DW-2:0];
               bit_cnt_nxt = '0;
               miso_nxt    = tx_data[DW-1];
            end
         end

         SHIFT: begin
            miso_nxt = miso;

            if (sclk_rise) begin
               rx_sh_nxt = {rx_sh[DW-2:0], mosi_s};
               if (bit_cnt != CNT_SAT) begin
                  bit_cnt_nxt = bit_cnt + 1'b1;
               end
            end

            // Zeros shift in behind the data, so miso reads 0 once all
            // DW bits have gone out.
            if (sclk_fall) begin
               miso_nxt  = tx_sh[DW-2];
               tx_sh_nxt = {tx_sh[DW-3:0], 1'b0};
            end

            // Evaluate on the post-capture values so a bit clocked in the
            // same cycle as the cs rise still counts toward the frame.
            if (cs_rise) begin
               state_nxt = IDLE;
               miso_nxt  = 1'b0;
               opcode    = rx_sh_nxt[DW-1 -: OPW];
               if (bit_cnt_nxt == CNT_FULL) begin
                  rx_data_nxt  = rx_sh_nxt;
                  rx_valid_nxt = 1'b1;
                  if (opcode == TRIG_OP) begin
                     trig_nxt     = 1'b1;
                     trig_cnt_nxt = trig_cnt + 1'b1;
                  end
               end else begin
                  err_len_nxt = 1'b1;
               end
            end
         end

         default: begin
            state_nxt = WAIT_IDLE;
         end
      endcase
   end

endmodule
